// File: rtl/rc522_spi_responder.sv
// SPI mode-0 slave modelling the RC522 register interface: 64x8 register file,
// FIFODataReg byte FIFO at 0x09, FIFOLevelReg at 0x0A and CommandReg observation.
module rc522_spi_responder #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clk_system,
  input  logic                          reset_system,
  input  logic                          clk_spi,
  input  logic                          cs_n,
  input  logic                          mosi,
  output logic                          miso,
  input  logic                          fifo_wr,
  input  logic [7:0]                    fifo_wdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          cmd_strobe,
  output logic [3:0]                    cmd_code
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [5:0]       ADDR_CMD  = 6'h01;
  localparam logic [5:0]       ADDR_FIFO = 6'h09;
  localparam logic [5:0]       ADDR_LVL  = 6'h0A;

  typedef enum logic [1:0] {IDLE, ADDR, WDATA, RDATA} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync;
  logic cs_s, sck_s, mosi_s, cs_prev, sck_prev;
  logic sck_rise_c, sck_fall_c, cs_fall_c;

  logic [2:0] bit_cnt;
  logic [6:0] shift_in;
  logic [7:0] rx_byte_c;
  logic       byte_done_c;
  logic [5:0] addr_q;
  logic [5:0] load_addr_c;
  logic       write_c, load_c, latch_c;

  logic [7:0] regs [64];
  logic [7:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic spi_push_c, spi_push_ok_c, loc_push_ok_c, pop_ok_c, flush_c, cmd_wr_c;
  logic [7:0] rd_data_c;
  logic [6:0] tx_shift;

  // cs_n chain resets low so a transaction already in progress is ignored until cs_n goes high
  always_ff @(posedge clk_system) begin
    if (reset_system) begin
      cs_sync   <= '0;
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_prev   <= 1'b0;
      sck_prev  <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], clk_spi};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_prev   <= cs_s;
      sck_prev  <= sck_s;
    end
  end

  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign sck_s       = sck_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign sck_rise_c  = sck_s & ~sck_prev;
  assign sck_fall_c  = ~sck_s & sck_prev;
  assign cs_fall_c   = ~cs_s & cs_prev;
  assign rx_byte_c   = {shift_in, mosi_s};
  assign load_addr_c = rx_byte_c[6:1];
  assign byte_done_c = sck_rise_c && !cs_s && (state != IDLE) && (bit_cnt == 3'd7);

  always_ff @(posedge clk_system) begin
    if (reset_system) state <= IDLE;
    else              state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state != IDLE && cs_s) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (cs_fall_c) state_next = ADDR;
        ADDR:    if (byte_done_c) state_next = rx_byte_c[7] ? RDATA : WDATA;
        default: state_next = state;
      endcase
    end
  end

  always_comb begin
    write_c = 1'b0;
    load_c  = 1'b0;
    latch_c = 1'b0;
    case (state)
      ADDR: begin
        latch_c = byte_done_c;
        load_c  = byte_done_c && rx_byte_c[7];
      end
      WDATA:   write_c = byte_done_c;
      RDATA:   load_c  = byte_done_c;
      default: ;
    endcase
  end

  // bit counter and MOSI shifter; a partial byte is dropped when cs_n rises
  always_ff @(posedge clk_system) begin
    if (reset_system) begin
      bit_cnt  <= '0;
      shift_in <= '0;
      addr_q   <= '0;
    end else begin
      if (state == IDLE || cs_s) begin
        bit_cnt <= '0;
      end else if (sck_rise_c) begin
        bit_cnt  <= bit_cnt + 3'd1;
        shift_in <= {shift_in[5:0], mosi_s};
      end
      if (latch_c) addr_q <= load_addr_c;
    end
  end

  assign spi_push_c    = write_c && (addr_q == ADDR_FIFO);
  assign flush_c       = write_c && (addr_q == ADDR_LVL) && rx_byte_c[7];
  assign cmd_wr_c      = write_c && (addr_q == ADDR_CMD);
  assign pop_ok_c      = load_c && (load_addr_c == ADDR_FIFO) && (fifo_level != '0);
  assign spi_push_ok_c = spi_push_c && (fifo_level < LVL_FULL);
  assign loc_push_ok_c = fifo_wr && !flush_c &&
                         (((fifo_level + LVL_W'(spi_push_ok_c)) < LVL_FULL) || pop_ok_c);

  always_ff @(posedge clk_system) begin
    if (reset_system) begin
      for (int i = 0; i < 64; i++) regs[i] <= '0;
    end else if (write_c && addr_q != ADDR_FIFO) begin
      regs[addr_q] <= rx_byte_c;
    end
  end

  always_ff @(posedge clk_system) begin
    if (reset_system) begin
      cmd_strobe <= 1'b0;
      cmd_code   <= '0;
    end else begin
      cmd_strobe <= cmd_wr_c;
      if (cmd_wr_c) cmd_code <= rx_byte_c[3:0];
    end
  end

  // SPI push lands first; a same-cycle local push takes the following slot
  always_ff @(posedge clk_system) begin
    if (spi_push_ok_c) fifo_mem[wr_ptr] <= rx_byte_c;
    if (loc_push_ok_c) fifo_mem[wr_ptr + PTR_W'(spi_push_ok_c)] <= fifo_wdata;
  end

  always_ff @(posedge clk_system) begin
    if (reset_system || flush_c) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      wr_ptr     <= wr_ptr + PTR_W'(spi_push_ok_c) + PTR_W'(loc_push_ok_c);
      rd_ptr     <= rd_ptr + PTR_W'(pop_ok_c);
      fifo_level <= fifo_level + LVL_W'(spi_push_ok_c) + LVL_W'(loc_push_ok_c)
                    - LVL_W'(pop_ok_c);
    end
  end

  always_comb begin
    rd_data_c = regs[load_addr_c];
    if (load_addr_c == ADDR_FIFO)     rd_data_c = pop_ok_c ? fifo_mem[rd_ptr] : 8'h00;
    else if (load_addr_c == ADDR_LVL) rd_data_c = 8'(fifo_level);
  end

  // MSB goes out at load; the falling edge that closes a byte (bit_cnt==0) must not shift
  always_ff @(posedge clk_system) begin
    if (reset_system) begin
      miso     <= 1'b0;
      tx_shift <= '0;
    end else if (load_c) begin
      miso     <= rd_data_c[7];
      tx_shift <= rd_data_c[6:0];
    end else if (cs_s || state != RDATA) begin
      miso     <= 1'b0;
      tx_shift <= '0;
    end else if (sck_fall_c && bit_cnt != 3'd0) begin
      miso     <= tx_shift[6];
      tx_shift <= {tx_shift[5:0], 1'b0};
    end
  end

endmodule
